uart_rx: RTL

- Receive deserializer for the AXI4-Lite UART.
- Sits between the external `rxd` pin and the UART control/register logic, which consumes bytes through a valid/ready holding register.
- Uses 16x oversampling and mid-bit sampling.
- Detects false starts, framing errors and overruns.
- Instantiated inside the UART wrapper only when RX is enabled.

---
 rtl/uart_rx.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// UART receive deserializer: synchronized rxd, oversampled mid-bit sampling, valid/ready holding register.
// Optional parity bit (parity_odd input, parity_err output) is compiled in with `define UART_RX_PARITY_EN.
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    input  logic                 rx_enable,
    input  logic [DIV_WIDTH-1:0] baud_div,
`ifdef UART_RX_PARITY_EN
    input  logic                 parity_odd,
    output logic                 parity_err,
`endif
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [SW-1:0] MID_LAST  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] BIT_LAST  = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t                state_q, state_d;
    logic                  rxd_meta, rxd_sync, rxd_prev;
    logic                  fall, tick;
    logic [DIV_WIDTH-1:0]  div_cnt;
    logic [SW-1:0]         samp_cnt;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_BITS-1:0]  shreg;
    logic                  clr_div, clr_samp, shift_en, stop_ok, stop_bad;
`ifdef UART_RX_PARITY_EN
    logic                  par_load, par_bad;
`endif

    assign fall = rxd_prev && !rxd_sync;
    assign tick = (div_cnt == baud_div);
    assign busy = (state_q != S_IDLE);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_d  = state_q;
        clr_div  = 1'b0;
        clr_samp = 1'b0;
        shift_en = 1'b0;
        stop_ok  = 1'b0;
        stop_bad = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_load = 1'b0;
`endif
        if (!rx_enable) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: if (fall) begin
                    state_d  = S_START;
                    clr_div  = 1'b1;
                    clr_samp = 1'b1;
                end
                // A start bit that is high again at mid-bit was a glitch.
                S_START: if (tick && samp_cnt == MID_LAST) begin
                    clr_samp = 1'b1;
                    state_d  = rxd_sync ? S_IDLE : S_DATA;
                end
                S_DATA: if (tick && samp_cnt == BIT_LAST) begin
                    clr_samp = 1'b1;
                    shift_en = 1'b1;
                    if (bit_cnt == DATA_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: if (tick && samp_cnt == BIT_LAST) begin
                    clr_samp = 1'b1;
                    par_load = 1'b1;
                    state_d  = S_STOP;
                end
`endif
                S_STOP: if (tick && samp_cnt == BIT_LAST) begin
                    stop_ok  = rxd_sync;
                    stop_bad = !rxd_sync;
                    state_d  = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rxd_meta    <= 1'b1;
            rxd_sync    <= 1'b1;
            rxd_prev    <= 1'b1;
            div_cnt     <= '0;
            samp_cnt    <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad     <= 1'b0;
            parity_err  <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values of the others.
            rxd_meta <= rxd;
            rxd_sync <= rxd_meta;
            rxd_prev <= rxd_sync;
            state_q  <= state_d;
            div_cnt  <= (clr_div || tick) ? '0 : div_cnt + DIV_WIDTH'(1);

            if (clr_samp)  samp_cnt <= '0;
            else if (tick) samp_cnt <= samp_cnt + SW'(1);

            if (clr_div)       bit_cnt <= '0;
            else if (shift_en) bit_cnt <= bit_cnt + BW'(1);

            if (shift_en) shreg <= {rxd_sync, shreg[DATA_BITS-1:1]};

            frame_err   <= stop_bad;
            overrun_err <= 1'b0;
            if (rx_valid && rx_ready) rx_valid <= 1'b0;
            // A completed byte is loaded only if the holding register is free or being drained now.
            if (stop_ok) begin
                if (rx_valid && !rx_ready) begin
                    overrun_err <= 1'b1;
                end else begin
                    rx_data  <= shreg;
                    rx_valid <= 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            if (par_load) par_bad <= ((^shreg) ^ rxd_sync) != parity_odd;
            parity_err <= stop_ok && par_bad;
`endif
        end
    end

endmodule
